bcd_serial_add_ctrl: RTL and testbench

//   Adds two NDIG-digit packed-BCD operands one digit per clock through a single

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_add.sv | 23 ++
 rtl/bcd_serial_add_ctrl.sv | 131 +++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the serial BCD adder.
// The top-level file header names the optional BCD_DIGIT_CHECK_EN build macro.
package bcd_pkg;
  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_ADD  = S_ADD,
    ST_DONE = S_DONE
  } state_e;
endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: binary sum of two digits plus carry, decimal-adjusted above 9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s    = sum[3:0];
    cout = 1'b0;
    // Any sum of 10..19 wraps past 16 once 6 is added, leaving the decimal digit.
    if (sum > {1'b0, BCD_MAX}) begin
      s    = sum[3:0] + BCD_ADJ;
      cout = 1'b1;
    end
  end
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one digit per clock through a single shared digit adder.
// Optional invalid-digit flag is built only when BCD_DIGIT_CHECK_EN is defined.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BCD_W*NDIG-1:0] x,
  input  logic [BCD_W*NDIG-1:0] y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BCD_W*NDIG:0]   o,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            dbg_state_o
);
  localparam int W  = BCD_W * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE and out_valid only in DONE, neither depends on the other side.
  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    x_q, x_d, y_q, y_d;
  logic [W:0]      o_q, o_d;
  logic [3:0]      dig_a, dig_b, dig_s;
  logic            dig_cout;
  logic            accept;

  assign dig_a  = x_q[idx_q*BCD_W +: BCD_W];
  assign dig_b  = y_q[idx_q*BCD_W +: BCD_W];
  assign accept = (state_q == ST_IDLE) && in_valid;

  bcd_digit_add u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    x_d     = x_q;
    y_d     = y_q;
    o_d     = o_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          carry_d = 1'b0;
          idx_d   = '0;
          o_d     = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        o_d[idx_q*BCD_W +: BCD_W] = dig_s;
        carry_d = dig_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(NDIG - 1)) begin
          o_d[W]  = dig_cout;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      x_q     <= x_d;
      y_q     <= y_d;
      o_q     <= o_d;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic err_q, err_d;

  // Sticky across the whole add so it is still visible while DONE presents the sum.
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (state_q == ST_ADD && (dig_a > BCD_MAX || dig_b > BCD_MAX)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q == ST_ADD) || (state_q == ST_DONE);
  assign o           = o_q;
  assign dbg_state_o = state_q;

  logic unused_accept;
  assign unused_accept = accept;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (NDIG=4): vector table plus reset-abort sequence.
module tb_bcd_serial_add_ctrl;
  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;
`ifdef BCD_DIGIT_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x, y;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   o;
  logic         busy;
  logic         err;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W:0]   exp_o;
    logic         exp_err;
    int           hold;
  } vec_t;

  vec_t vecs[9];

  bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .o           (o),
    .busy        (busy),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one full transaction, scrambling x/y/in_valid while the block is busy.
  task automatic run_add(input vec_t v);
    logic [W:0] exp_o;
    int cnt;
    out_ready = (v.hold == 0);
    check("idle_in_ready", {16'd0, in_ready}, 17'd1);
    in_valid = 1'b1;
    x = v.x;
    y = v.y;
    tick();
    exp_q.push_back(v.exp_o);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      check("busy_in_ready", {16'd0, in_ready}, 17'd0);
      in_valid = 1'($urandom_range(0, 1));
      x = W'($urandom);
      y = W'($urandom);
      tick();
      cnt++;
    end
    in_valid = 1'b0;
    check("latency", W'(cnt), W'(NDIG));
    check("out_valid", {16'd0, out_valid}, 17'd1);
    check("busy_done", {16'd0, busy}, 17'd1);
    exp_o = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("sum", o, exp_o);
    check("err", {16'd0, err}, {16'd0, v.exp_err});
    for (int i = 0; i < v.hold; i++) begin
      tick();
      check("hold_valid", {16'd0, out_valid}, 17'd1);
      check("hold_sum", o, exp_o);
      check("hold_in_ready", {16'd0, in_ready}, 17'd0);
    end
    out_ready = 1'b1;
    tick();
    check("back_idle_ready", {16'd0, in_ready}, 17'd1);
    check("back_idle_valid", {16'd0, out_valid}, 17'd0);
  endtask

  initial begin
    vecs[0] = '{16'h0378, 16'h0689, 17'h01067, 1'b0, 0};
    vecs[1] = '{16'h9999, 16'h7779, 17'h17778, 1'b0, 0};
    vecs[2] = '{16'h0000, 16'h0066, 17'h00066, 1'b0, 0};
    vecs[3] = '{16'h0437, 16'h0578, 17'h01015, 1'b0, 5};
    vecs[4] = '{16'h0889, 16'h0312, 17'h01201, 1'b0, 0};
    vecs[5] = '{16'h0000, 16'h0000, 17'h00000, 1'b0, 0};
    vecs[6] = '{16'h9999, 16'h9999, 17'h19998, 1'b0, 2};
    vecs[7] = '{16'h00A0, 16'h0001, 17'h00101, ERR_ON, 0};
    vecs[8] = '{16'h0033, 16'h0033, 17'h00066, 1'b0, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    tick();
    tick();
    check("rst_in_ready", {16'd0, in_ready}, 17'd1);
    check("rst_out_valid", {16'd0, out_valid}, 17'd0);
    check("rst_busy", {16'd0, busy}, 17'd0);
    check("rst_err", {16'd0, err}, 17'd0);
    check("rst_o", o, 17'd0);
    check("rst_state", {15'd0, dbg_state}, 17'd0);
    rst = 1'b0;
    tick();
    check("idle_hold", {16'd0, in_ready}, 17'd1);

    for (int i = 0; i < 9; i++) run_add(vecs[i]);

    // Reset asserted on the second ADD edge aborts the pending sum.
    in_valid = 1'b1;
    x = 16'h1587;
    y = 16'h0578;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", {16'd0, in_ready}, 17'd1);
    check("abort_out_valid", {16'd0, out_valid}, 17'd0);
    check("abort_busy", {16'd0, busy}, 17'd0);
    check("abort_o", o, 17'd0);
    run_add('{16'h0033, 16'h0033, 17'h00066, 1'b0, 0});

    check("scoreboard_empty", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
